// File: rtl/ixc_assign_pkg.sv
// Shared definitions for the parametrised elastic assign pipe.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package ixc_assign_pkg;

  // Deepest retimed assign the template library instantiates.
  localparam int MAX_DEPTH = 16;

  // Occupancy counter width: enough bits for 0..depth, never narrower than 1.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Legal parameter combination for ixc_assign_pipe.
  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 0) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/ixc_assign_stage.sv
// One elastic register stage (valid/ready skid-free pipeline register).
// Latency: 1 cycle from in_* handshake to out_valid.
// Backpressure: in_ready = (empty | out_ready) & ~flush, combinational from out_ready.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream side;
//        out_valid/out_ready/out_data downstream side; flush clears the valid bit.
module ixc_assign_stage
  import ixc_assign_pkg::*;
#(
  parameter int               WIDTH      = 11,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             in_fire;

  assign in_ready = (~valid_q | out_ready) & ~flush;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_DATA;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_fire) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      // Data only moves on an accepted word, so an empty last stage never
      // disturbs L between words.
      if (in_fire) begin
        data_q <= in_data;
      end
    end
  end

  // out_valid is the raw held bit; the top gates the final l_valid with flush
  // so occupancy still reports held words during the flush cycle.
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/ixc_assign_pipe.sv
// Parametrised assign R -> L through DEPTH elastic stages (DEPTH=0: plain wire).
// Latency: DEPTH cycles R to L; full throughput of one word per cycle.
// Backpressure: l_ready ripples combinationally back to r_ready; flush forces both sides idle.
//
// Ports: clk, rst_n (async active-low); R/r_valid/r_ready input side;
//        L/l_valid/l_ready output side; flush (sync discard); occupancy (valid stage count).
module ixc_assign_pipe
  import ixc_assign_pkg::*;
#(
  parameter int               WIDTH      = 11,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int              CW         = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] R,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] L,
  output logic             l_valid,
  input  logic             l_ready,
  input  logic             flush,
  output logic [CW-1:0]    occupancy
);

  if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("ixc_assign_pipe: WIDTH must be >= 1 and DEPTH in 0..%0d", MAX_DEPTH);
  end

  if (DEPTH == 0) begin : g_bypass
    // Pure combinational assign; clock and reset are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign L         = R;
    assign l_valid   = r_valid & ~flush;
    assign r_ready   = l_ready & ~flush;
    assign occupancy = '0;
  end else begin : g_pipe
    // Index k is the link feeding stage k; index DEPTH is the output link.
    logic [DEPTH:0]   vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat [DEPTH+1];
    logic [CW-1:0]    occ_sum;

    assign vld[0]     = r_valid;
    assign dat[0]     = R;
    assign r_ready    = rdy[0];
    assign rdy[DEPTH] = l_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      ixc_assign_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld[k]),
        .in_ready  (rdy[k]),
        .in_data   (dat[k]),
        .out_valid (vld[k+1]),
        .out_ready (rdy[k+1]),
        .out_data  (dat[k+1]),
        .flush     (flush)
      );
    end

    assign L       = dat[DEPTH];
    assign l_valid = vld[DEPTH] & ~flush;

    // Popcount of the stage valid flops; tracks held words exactly.
    always_comb begin
      occ_sum = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        occ_sum = occ_sum + CW'(vld[k]);
      end
    end

    assign occupancy = occ_sum;
  end

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed bench for ixc_assign_pipe: DEPTH=2 main instance, DEPTH=0 bypass, DEPTH=4.
// Scoreboard queues hold accepted words; each output handshake pops and compares.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ixc_assign_pipe;

  logic clk;
  logic rst_n;

  // DEPTH = 2 instance
  logic [10:0] R2, L2;
  logic        rv2, rr2, lv2, lr2, fl2;
  logic [1:0]  occ2;
  // DEPTH = 0 instance
  logic [10:0] R0, L0;
  logic        rv0, rr0, lv0, lr0, fl0;
  logic [0:0]  occ0;
  // DEPTH = 4 instance
  logic [10:0] R4, L4;
  logic        rv4, rr4, lv4, lr4, fl4;
  logic [2:0]  occ4;

  int n_chk;
  int n_bad;
  logic [10:0] q2[$];
  logic [10:0] q4[$];

  ixc_assign_pipe #(.WIDTH(11), .DEPTH(2), .RESET_DATA(11'h2A5)) u_dut (
    .clk(clk), .rst_n(rst_n), .R(R2), .r_valid(rv2), .r_ready(rr2),
    .L(L2), .l_valid(lv2), .l_ready(lr2), .flush(fl2), .occupancy(occ2)
  );

  ixc_assign_pipe #(.WIDTH(11), .DEPTH(0), .RESET_DATA(11'h000)) u_d0 (
    .clk(clk), .rst_n(rst_n), .R(R0), .r_valid(rv0), .r_ready(rr0),
    .L(L0), .l_valid(lv0), .l_ready(lr0), .flush(fl0), .occupancy(occ0)
  );

  ixc_assign_pipe #(.WIDTH(11), .DEPTH(4), .RESET_DATA(11'h000)) u_d4 (
    .clk(clk), .rst_n(rst_n), .R(R4), .r_valid(rv4), .r_ready(rr4),
    .L(L4), .l_valid(lv4), .l_ready(lr4), .flush(fl4), .occupancy(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake-level rules, update scoreboards, advance to next falling edge.
  task automatic tick();
    logic fl2_s, fl4_s;
    #1;
    fl2_s = fl2;
    fl4_s = fl4;
    check("d2_occ", 32'(occ2), 32'(q2.size()));
    check("d2_r_ready", 32'(rr2), 32'(!fl2 && (q2.size() < 2 || lr2)));
    if (fl2) check("d2_l_valid_flush", 32'(lv2), 32'(0));
    if (lv2 && lr2) begin
      check("d2_pop_nonempty", 32'(q2.size() != 0), 32'(1));
      if (q2.size() != 0) check("d2_L_order", 32'(L2), 32'(q2.pop_front()));
    end
    if (rv2 && rr2) q2.push_back(R2);

    check("d4_occ", 32'(occ4), 32'(q4.size()));
    check("d4_r_ready", 32'(rr4), 32'(!fl4 && (q4.size() < 4 || lr4)));
    if (lv4 && lr4) begin
      check("d4_pop_nonempty", 32'(q4.size() != 0), 32'(1));
      if (q4.size() != 0) check("d4_L_order", 32'(L4), 32'(q4.pop_front()));
    end
    if (rv4 && rr4) q4.push_back(R4);

    @(posedge clk);
    if (fl2_s) q2.delete();
    if (fl4_s) q4.delete();
    @(negedge clk);
  endtask

  initial begin
    int i;
    int c;
    logic       hold_vld;
    logic [10:0] hold_l;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    R2 = '0; rv2 = 1'bx; lr2 = 1'b1; fl2 = 1'b0;
    R0 = '0; rv0 = 1'b0; lr0 = 1'b0; fl0 = 1'b0;
    R4 = '0; rv4 = 1'b0; lr4 = 1'b1; fl4 = 1'b0;

    // Reset, with an unknown r_valid while reset is held
    repeat (3) @(negedge clk);
    check("rst_L", 32'(L2), 32'h2A5);
    check("rst_l_valid", 32'(lv2), 32'(0));
    check("rst_occ", 32'(occ2), 32'(0));
    check("rst_d4_L", 32'(L4), 32'h000);
    rv2 = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_r_ready", 32'(rr2), 32'(1));
    check("rst_L_after", 32'(L2), 32'h2A5);

    // Stream 0x001..0x010 with l_ready high; check 2-cycle latency of first word
    for (i = 1; i <= 16; i++) begin
      R2 = 11'(i); rv2 = 1'b1; lr2 = 1'b1;
      #1;
      if (i == 2) check("lat_not_yet", 32'(lv2), 32'(0));
      if (i == 3) begin
        check("lat_valid", 32'(lv2), 32'(1));
        check("lat_first", 32'(L2), 32'h001);
      end
      if (i > 3) check("stream_occ", 32'(occ2), 32'(2));
      tick();
    end
    rv2 = 1'b0;
    for (int k = 0; k < 20 && q2.size() != 0; k++) tick();
    check("stream_drain", 32'(q2.size()), 32'(0));

    // Same stream with l_ready low for cycles 3..7
    i = 1; c = 0; hold_vld = 1'b0; hold_l = '0;
    while (i <= 16 && c < 100) begin
      R2 = 11'(i); rv2 = 1'b1; lr2 = !(c >= 3 && c <= 7);
      #1;
      if (hold_vld) check("stall_L_hold", 32'(L2), 32'(hold_l));
      if (c == 7) begin
        check("stall_full_occ", 32'(occ2), 32'(2));
        check("stall_full_rdy", 32'(rr2), 32'(0));
      end
      hold_vld = lv2 && !lr2;
      hold_l = L2;
      if (rr2) i++;
      c++;
      tick();
    end
    check("stall_all_sent", 32'(i), 32'(17));
    rv2 = 1'b0; lr2 = 1'b1;
    for (int k = 0; k < 20 && q2.size() != 0; k++) tick();
    check("stall_drain", 32'(q2.size()), 32'(0));

    // Fill with 0x7FF, 0x400 then flush; those words must never come out
    lr2 = 1'b0; rv2 = 1'b1;
    R2 = 11'h7FF; tick();
    R2 = 11'h400; tick();
    check("flush_pre_occ", 32'(occ2), 32'(2));
    fl2 = 1'b1; lr2 = 1'b1; R2 = 11'h123;
    #1;
    check("flush_l_valid", 32'(lv2), 32'(0));
    check("flush_r_ready", 32'(rr2), 32'(0));
    tick();
    fl2 = 1'b0; rv2 = 1'b0;
    #1;
    check("flush_occ0", 32'(occ2), 32'(0));
    check("flush_lv0", 32'(lv2), 32'(0));
    // Multi-cycle flush with a word offered: nothing enters
    fl2 = 1'b1; rv2 = 1'b1; R2 = 11'h0AA;
    repeat (3) tick();
    fl2 = 1'b0;
    R2 = 11'h0AB; tick();
    R2 = 11'h0AC; tick();
    rv2 = 1'b0;
    for (int k = 0; k < 20 && q2.size() != 0; k++) tick();
    check("flush_drain", 32'(q2.size()), 32'(0));

    // DEPTH=0 bypass
    R0 = 11'h155; rv0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lr0 = (k % 2) == 1;
      #1;
      check("d0_L", 32'(L0), 32'h155);
      check("d0_l_valid", 32'(lv0), 32'(1));
      check("d0_r_ready", 32'(rr0), 32'(k % 2));
      check("d0_occ", 32'(occ0), 32'(0));
      @(negedge clk);
    end
    fl0 = 1'b1; lr0 = 1'b1;
    #1;
    check("d0_flush_lv", 32'(lv0), 32'(0));
    check("d0_flush_rr", 32'(rr0), 32'(0));
    fl0 = 1'b0; rv0 = 1'b0;
    @(negedge clk);

    // DEPTH=4: fill, then asynchronous reset between edges
    rv4 = 1'b1; lr4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      R4 = 11'h301 + 11'(k);
      tick();
    end
    rv4 = 1'b0;
    #1;
    check("d4_full_occ", 32'(occ4), 32'(4));
    check("d4_full_rr", 32'(rr4), 32'(0));
    check("d4_full_head", 32'(L4), 32'h301);
    #2;
    rst_n = 1'b0;
    #1;
    check("d4_arst_lv", 32'(lv4), 32'(0));
    check("d4_arst_occ", 32'(occ4), 32'(0));
    check("d4_arst_L", 32'(L4), 32'h000);
    check("d2_arst_L", 32'(L2), 32'h2A5);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    lr4 = 1'b1; rv4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      R4 = 11'h311 + 11'(k);
      tick();
    end
    rv4 = 1'b0;
    for (int k = 0; k < 20 && q4.size() != 0; k++) tick();
    check("d4_drain", 32'(q4.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
